window_gen_5x5: RTL and testbench

// - Producer side of the 5x5 convolution interface: turns a raster-order 8-bit pixel stream into
//   25-pixel windows packed on a 200-bit bus, with a valid strobe, for fir_filter's pixel_data input.
// - Sits between the pixel source (camera/DMA) and fir_filter; holds 4 image lines in line memories.
// - Emits windows only where all 25 taps lie inside the frame (no border padding).

---
 rtl/window_gen_5x5_pkg.sv | 14 +
 rtl/window_gen_5x5_if.sv | 27 ++
 rtl/window_gen_5x5_line_buffer.sv | 24 ++
 rtl/window_gen_5x5.sv | 117 +++++++++++
 tb/tb_window_gen_5x5.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/window_gen_5x5_pkg.sv
// Shared definitions for the 5x5 window interface (producer and fir_filter side).
package window_gen_5x5_pkg;

  localparam int PIX_W       = 8;
  localparam int KERNEL_SIZE = 5;
  localparam int KERNEL_TAPS = KERNEL_SIZE * KERNEL_SIZE;
  localparam int WINDOW_W    = KERNEL_TAPS * PIX_W;

  // Tap position inside the packed window: row 0 is the oldest line, col 0 the leftmost pixel.
  function automatic int tap_idx(input int row, input int col);
    return row * KERNEL_SIZE + col;
  endfunction

endpackage

// File: rtl/window_gen_5x5_if.sv
// Pixel stream in, packed 5x5 window out.
interface window_gen_5x5_if
  import window_gen_5x5_pkg::*;
#(
  parameter int PIX_W = window_gen_5x5_pkg::PIX_W
);

  logic [PIX_W-1:0]             in_pixel;
  logic                         in_pixel_valid;
  logic                         in_sof;
  logic [KERNEL_TAPS*PIX_W-1:0] pixel_data;
  logic                         pixel_data_valid;
  logic                         frame_done;

  // Pixel source / window consumer side.
  modport master (
    output in_pixel, in_pixel_valid, in_sof,
    input  pixel_data, pixel_data_valid, frame_done
  );

  // Window generator side.
  modport slave (
    input  in_pixel, in_pixel_valid, in_sof,
    output pixel_data, pixel_data_valid, frame_done
  );

endinterface

// File: rtl/window_gen_5x5_line_buffer.sv
// One image line of storage; the old value at addr is visible combinationally so the
// caller reads before it overwrites in the same cycle.
module window_gen_5x5_line_buffer #(
  parameter int DEPTH = 512,
  parameter int PIX_W = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Contents are deliberately not reset; the top masks stale lines with row gating.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/window_gen_5x5.sv
// Raster pixel stream to 5x5 windows; windows only where all taps are inside the frame.
module window_gen_5x5 #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int PIX_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  window_gen_5x5_if.slave  bus
);

  import window_gen_5x5_pkg::*;

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int K  = KERNEL_SIZE;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

  logic [CW-1:0]    col_cnt, col_eff;
  logic [RW-1:0]    row_cnt, row_eff;
  logic             accept, sof;
  logic [PIX_W-1:0] rd [K-1];
  logic [PIX_W-1:0] col_vec [K];
  logic [PIX_W-1:0] win [K][K];
  logic [K*K*PIX_W-1:0] packed_win;
  logic             valid_q, done_q;

  assign accept = bus.in_pixel_valid;
  assign sof    = accept & bus.in_sof;

  // A start-of-frame pixel is (0,0) no matter where the counters were.
  assign col_eff = sof ? '0 : col_cnt;
  assign row_eff = sof ? '0 : row_cnt;

  // Four cascaded line memories: mem0 holds the previous line, mem3 the oldest.
  for (genvar k = 0; k < K - 1; k++) begin : g_line
    logic [PIX_W-1:0] wdata;
    if (k == 0) begin : g_first
      assign wdata = bus.in_pixel;
    end else begin : g_next
      assign wdata = rd[k-1];
    end
    window_gen_5x5_line_buffer #(
      .DEPTH (IMG_WIDTH),
      .PIX_W (PIX_W),
      .AW    (CW)
    ) u_line (
      .clk   (clk),
      .addr  (col_eff),
      .we    (accept),
      .wdata (wdata),
      .rdata (rd[k])
    );
  end

  // New window column, oldest line at row 0, live pixel at row 4.
  always_comb begin
    for (int r = 0; r < K - 1; r++) col_vec[r] = rd[K-2-r];
    col_vec[K-1] = bus.in_pixel;
  end

  // Raster position tracking with frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (col_eff == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
      end else begin
        col_cnt <= col_eff + 1'b1;
        row_cnt <= row_eff;
      end
    end
  end

  // Window shift register: every accepted pixel shifts left and loads the new column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
        win[r][K-1] <= col_vec[r];
      end
    end
  end

  // Strobes: valid only once the window is fully inside the frame, done on the last window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= accept && (row_eff >= ROW_MIN) && (col_eff >= COL_MIN);
      done_q  <= accept && (row_eff == ROW_LAST) && (col_eff == COL_LAST);
    end
  end

  // Pack taps onto the window bus.
  always_comb begin
    packed_win = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        packed_win[PIX_W*tap_idx(r, c) +: PIX_W] = win[r][c];
  end

  assign bus.pixel_data       = packed_win;
  assign bus.pixel_data_valid = valid_q;
  assign bus.frame_done       = done_q;

endmodule

// File: tb/tb_window_gen_5x5.sv
// Directed bench for window_gen_5x5 on an 8x8 ramp image (pixel = row*8 + col).
module tb_window_gen_5x5;

  localparam int W = 8;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  window_gen_5x5_if #(.PIX_W(8)) bus();

  window_gen_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [199:0] data;
    logic         fd;
  } exp_t;

  typedef struct {
    int         r;
    int         c;
    logic [7:0] t0;
    logic [7:0] t12;
    logic [7:0] t24;
    logic       fd;
  } vec_t;

  exp_t         exp_q[$];
  vec_t         tbl[6];
  int           n_vec = 0;
  int           n_err = 0;
  int           fd_cnt = 0;
  int           win_cnt = 0;
  bit           capture = 0;
  logic [199:0] got[16];
  logic         got_fd[16];

  // Expected window centred-bottom-right at (r,c) of the ramp image.
  function automatic logic [199:0] win_at(input int r, input int c);
    logic [199:0] d;
    d = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        d[8*(i*5+j) +: 8] = 8'(((r - 4 + i) * W) + (c - 4 + j));
    return d;
  endfunction

  task automatic chk_bits(input string name, input logic [199:0] act, input logic [199:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Scoreboard: each output window must be the next expected one, in order.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.pixel_data_valid === 1'b1) begin
        if (capture && win_cnt < 16) begin
          got[win_cnt]    = bus.pixel_data;
          got_fd[win_cnt] = bus.frame_done;
        end
        win_cnt++;
        if (bus.frame_done === 1'b1) fd_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_window: got %h want none", bus.pixel_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk_bits("window_data", bus.pixel_data, e.data);
          chk_bits("frame_done", 200'(bus.frame_done), 200'(e.fd));
        end
      end else if (bus.frame_done === 1'b1) begin
        n_vec++;
        n_err++;
        $display("FAIL done_without_valid: got 1 want 0");
      end
    end
  end

  task automatic push_frame();
    for (int r = 4; r < H; r++)
      for (int c = 4; c < W; c++) begin
        exp_t e;
        e.data = win_at(r, c);
        e.fd   = (r == H - 1) && (c == W - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic send(input logic [7:0] p, input bit sof, input bit gaps);
    if (gaps) begin
      while ($urandom_range(1, 0) == 0) begin
        @(posedge clk); #1;
        bus.in_pixel_valid = 1'b0;
        bus.in_sof         = 1'b0;
        bus.in_pixel       = 8'($urandom);
      end
    end
    @(posedge clk); #1;
    bus.in_pixel       = p;
    bus.in_pixel_valid = 1'b1;
    bus.in_sof         = sof;
  endtask

  task automatic send_pixels(input int count, input bit sof, input bit gaps);
    for (int i = 0; i < count; i++) send(8'(i), sof && (i == 0), gaps);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.in_pixel_valid = 1'b0;
      bus.in_sof         = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fd0;

    tbl[0] = '{4, 4,  0, 18, 36, 1'b0};
    tbl[1] = '{4, 5,  1, 19, 37, 1'b0};
    tbl[2] = '{4, 7,  3, 21, 39, 1'b0};
    tbl[3] = '{5, 4,  8, 26, 44, 1'b0};
    tbl[4] = '{6, 6, 18, 36, 54, 1'b0};
    tbl[5] = '{7, 7, 27, 45, 63, 1'b1};

    bus.in_pixel       = '0;
    bus.in_pixel_valid = 1'b0;
    bus.in_sof         = 1'b0;
    rst_n              = 1'b0;
    #1;
    chk_bits("reset_data", bus.pixel_data, '0);
    chk_int("reset_valid", int'(bus.pixel_data_valid), 0);
    chk_int("reset_done", int'(bus.frame_done), 0);
    #20 rst_n = 1'b1;

    // Frame 1: continuous valid, captured for spot checks.
    capture = 1;
    win_cnt = 0;
    push_frame();
    send_pixels(W * H, 1, 0);
    idle(4);
    capture = 0;
    chk_int("f1_window_count", win_cnt, 16);
    chk_int("f1_pending", exp_q.size(), 0);
    chk_int("f1_done_count", fd_cnt, 1);
    for (int i = 0; i < 6; i++) begin
      int k;
      k = (tbl[i].r - 4) * 4 + (tbl[i].c - 4);
      chk_bits("tbl_tap0",  200'(got[k][0 +: 8]),  200'(tbl[i].t0));
      chk_bits("tbl_tap12", 200'(got[k][96 +: 8]), 200'(tbl[i].t12));
      chk_bits("tbl_tap24", 200'(got[k][192 +: 8]), 200'(tbl[i].t24));
      chk_bits("tbl_done",  200'(got_fd[k]),        200'(tbl[i].fd));
    end

    // Frame 2: random valid gaps.
    win_cnt = 0;
    fd0 = fd_cnt;
    push_frame();
    send_pixels(W * H, 1, 1);
    idle(4);
    chk_int("gaps_window_count", win_cnt, 16);
    chk_int("gaps_pending", exp_q.size(), 0);
    chk_int("gaps_done_count", fd_cnt - fd0, 1);

    // Abandoned partial frame then restart with sof.
    win_cnt = 0;
    fd0 = fd_cnt;
    send_pixels(20, 1, 0);
    push_frame();
    send_pixels(W * H, 1, 0);
    idle(4);
    chk_int("restart_window_count", win_cnt, 16);
    chk_int("restart_pending", exp_q.size(), 0);
    chk_int("restart_done_count", fd_cnt - fd0, 1);

    // Reset mid-frame after 40 pixels, then a frame without sof.
    win_cnt = 0;
    for (int c = 4; c < 7; c++) begin
      exp_t e;
      e.data = win_at(4, c);
      e.fd   = 1'b0;
      exp_q.push_back(e);
    end
    send_pixels(40, 1, 0);
    @(posedge clk); #1;
    bus.in_pixel_valid = 1'b0;
    chk_int("pre_reset_valid", int'(bus.pixel_data_valid), 1);
    chk_bits("pre_reset_data", bus.pixel_data, win_at(4, 7));
    #1 rst_n = 1'b0;
    #1;
    chk_bits("midreset_data", bus.pixel_data, '0);
    chk_int("midreset_valid", int'(bus.pixel_data_valid), 0);
    chk_int("midreset_done", int'(bus.frame_done), 0);
    chk_int("midreset_pending", exp_q.size(), 0);
    #20 rst_n = 1'b1;
    win_cnt = 0;
    fd0 = fd_cnt;
    push_frame();
    send_pixels(W * H, 0, 0);
    idle(4);
    chk_int("postreset_window_count", win_cnt, 16);
    chk_int("postreset_pending", exp_q.size(), 0);
    chk_int("postreset_done_count", fd_cnt - fd0, 1);

    // Two back-to-back frames, sof only on the first.
    win_cnt = 0;
    fd0 = fd_cnt;
    push_frame();
    push_frame();
    send_pixels(W * H, 1, 0);
    send_pixels(W * H, 0, 0);
    idle(4);
    chk_int("b2b_window_count", win_cnt, 32);
    chk_int("b2b_pending", exp_q.size(), 0);
    chk_int("b2b_done_count", fd_cnt - fd0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
